// File: rtl/dmem_responder_pkg.sv
// Shared load/store definitions: funct3 size codes, responder FSM states,
// and the response register layout.
package LOAD_STORE_FNS;

  typedef enum logic [2:0] {
    BYTE   = 3'b000,
    HALF   = 3'b001,
    WORD   = 3'b010,
    BYTE_U = 3'b100,
    HALF_U = 3'b101
  } funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam int DMEM_MAX_LATENCY = 4;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } dmem_rsp_t;

  function automatic logic funct3_is_unsigned(logic [2:0] f3);
    return (f3 == BYTE_U) || (f3 == HALF_U);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the LSU (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder_lane.sv
// lsu_lane_align: combinational funct3/byte-offset decode into lane enables,
// replicated store data, extended load data and error flags.
// DMEM_MISALIGN_TRAP_EN: report misaligned HALF/WORD; otherwise they align down.
module lsu_lane_align
  import LOAD_STORE_FNS::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_rep_o,
  output logic [31:0] rdata_ext_o,
  output logic        illegal_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Half selection ignores addr[0], which is what gives the align-down behaviour.
  assign byte_sel = rdata_word_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = addr_lo_i[1] ? rdata_word_i[31:16] : rdata_word_i[15:0];

  always_comb begin
    be_o         = 4'b0000;
    wdata_rep_o  = '0;
    rdata_ext_o  = '0;
    illegal_o    = 1'b0;
    misaligned_o = 1'b0;
    case (funct3_i)
      BYTE, BYTE_U: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_rep_o = {4{wdata_i[7:0]}};
        rdata_ext_o = (funct3_i == BYTE) ? {{24{byte_sel[7]}}, byte_sel}
                                         : {24'b0, byte_sel};
      end
      HALF, HALF_U: begin
        be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_rep_o = {2{wdata_i[15:0]}};
        rdata_ext_o = (funct3_i == HALF) ? {{16{half_sel[15]}}, half_sel}
                                         : {16'b0, half_sel};
`ifdef DMEM_MISALIGN_TRAP_EN
        misaligned_o = addr_lo_i[0];
`endif
      end
      WORD: begin
        be_o        = 4'b1111;
        wdata_rep_o = wdata_i;
        rdata_ext_o = rdata_word_i;
`ifdef DMEM_MISALIGN_TRAP_EN
        misaligned_o = |addr_lo_i;
`endif
      end
      default: illegal_o = 1'b1;
    endcase
    if (we_i && funct3_is_unsigned(funct3_i))
      illegal_o = 1'b1;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store per handshake, byte-lane commit into
// a local word array, fixed-latency response. LATENCY must be 1..4.
module dmem_responder
  import LOAD_STORE_FNS::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(DMEM_MAX_LATENCY);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  dmem_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  dmem_rsp_t     rsp_q, rsp_d;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [AW-1:0] widx;
  logic [31:0]   rd_word;
  logic [3:0]    be;
  logic [31:0]   wdata_rep, rdata_ext;
  logic          illegal, misaligned, oob, req_err;
  logic          accept, wr_en;

  assign widx    = bus.req_addr[2 +: AW];
  assign rd_word = mem_q[widx];
  assign oob     = |bus.req_addr[31:AW+2];
  assign req_err = illegal | misaligned | oob;

  lsu_lane_align u_align (
    .we_i         (bus.req_we),
    .funct3_i     (bus.req_funct3),
    .addr_lo_i    (bus.req_addr[1:0]),
    .wdata_i      (bus.req_wdata),
    .rdata_word_i (rd_word),
    .be_o         (be),
    .wdata_rep_o  (wdata_rep),
    .rdata_ext_o  (rdata_ext),
    .illegal_o    (illegal),
    .misaligned_o (misaligned)
  );

  // req_ready already carries !rst, so a reset coincident with a request blocks the write.
  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp_q.rdata;
  assign bus.rsp_err   = rsp_q.err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rsp_d   = rsp_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rsp_d.err   = req_err;
          rsp_d.rdata = (req_err || bus.req_we) ? 32'h0 : rdata_ext;
          wr_en       = bus.req_we && !req_err;
          cnt_d       = CNT_INIT;
          state_d     = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CW'(1))
          state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
    end
  end

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l])
          mem_q[widx][8*l +: 8] <= wdata_rep[8*l +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=1 instance for the data path
// and error cases, a LATENCY=3 instance for WAIT-state timing and reset.
module tb_dmem_responder;
  import LOAD_STORE_FNS::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder_if b1();
  dmem_responder_if b2();

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut (
    .clk(clk), .rst(rst), .bus(b1)
  );

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(3)) dut2 (
    .clk(clk), .rst(rst2), .bus(b2)
  );

  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rd,
                      output logic er, output int lat);
    int n;
    @(negedge clk);
    b1.req_valid  = 1'b1;
    b1.req_we     = we;
    b1.req_funct3 = f3;
    b1.req_addr   = addr;
    b1.req_wdata  = wdata;
    b1.rsp_ready  = 1'b1;
    n = 0;
    while (!b1.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    b1.req_valid = 1'b0;
    lat = 1;
    while (!b1.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = b1.rsp_rdata;
    er = b1.rsp_err;
    checks++;
    if (b1.rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL xact_timeout addr=%h got rsp_valid=%b want 1", addr, b1.rsp_valid);
    end
  endtask

  task automatic test_reset();
    b1.req_valid = 0; b1.req_we = 0; b1.req_funct3 = 0; b1.req_addr = 0;
    b1.req_wdata = 0; b1.rsp_ready = 1;
    b2.req_valid = 0; b2.req_we = 0; b2.req_funct3 = 0; b2.req_addr = 0;
    b2.req_wdata = 0; b2.rsp_ready = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (b1.req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got %b want 0", b1.req_ready); end
    checks++;
    if (b1.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %b want 0", b1.rsp_valid); end
    checks++;
    if (b1.rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got %h want 0", b1.rsp_rdata); end
    checks++;
    if (b1.rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got %b want 0", b1.rsp_err); end
    rst = 0;
    rst2 = 0;
    @(negedge clk);
    checks++;
    if (b1.req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_req_ready got %b want 1", b1.req_ready); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, WORD, 32'h10, 32'hDEADBEEF, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL word_store got err=%b rdata=%h want 0/0", er, rd); end
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL word_store_latency got %0d want 1", lat); end
    xact(1'b0, WORD, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin failures++; $display("FAIL word_load got %h/%b want deadbeef/0", rd, er); end
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL word_load_latency got %0d want 1", lat); end
  endtask

  task automatic test_subword_load();
    logic [2:0]  f3  [4] = '{BYTE, BYTE_U, HALF, HALF_U};
    logic [31:0] ad  [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
    logic [31:0] exp [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
    logic [31:0] rd; logic er; int lat;
    for (int i = 0; i < 4; i++) begin
      xact(1'b0, f3[i], ad[i], 32'h0, rd, er, lat);
      checks++;
      if (rd !== exp[i] || er !== 1'b0) begin
        failures++;
        $display("FAIL subword_load[%0d] got %h/%b want %h/0", i, rd, er, exp[i]);
      end
    end
  endtask

  task automatic test_byte_store();
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, BYTE, 32'h11, 32'h0000005A, rd, er, lat);
    xact(1'b0, WORD, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD5AEF || er !== 1'b0) begin failures++; $display("FAIL byte_store got %h/%b want dead5aef/0", rd, er); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] exp_ld, exp_word;
    logic        exp_err;
`ifdef DMEM_MISALIGN_TRAP_EN
    exp_err = 1'b1; exp_ld = 32'h0; exp_word = 32'hDEAD5AEF;
`else
    exp_err = 1'b0; exp_ld = 32'h00005AEF; exp_word = 32'hDEAD1234;
`endif
    xact(1'b0, HALF, 32'h11, 32'h0, rd, er, lat);
    checks++;
    if (rd !== exp_ld || er !== exp_err) begin failures++; $display("FAIL misalign_load got %h/%b want %h/%b", rd, er, exp_ld, exp_err); end
    xact(1'b1, HALF, 32'h11, 32'h00001234, rd, er, lat);
    checks++;
    if (er !== exp_err) begin failures++; $display("FAIL misalign_store_err got %b want %b", er, exp_err); end
    xact(1'b0, WORD, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== exp_word) begin failures++; $display("FAIL misalign_store_effect got %h want %h", rd, exp_word); end
    xact(1'b1, WORD, 32'h10, 32'hDEAD5AEF, rd, er, lat);
  endtask

  task automatic test_errors();
    logic        we  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3  [6] = '{3'b100, 3'b101, 3'b011, 3'b110, 3'b010, 3'b010};
    logic [31:0] ad  [6] = '{32'h10, 32'h10, 32'h10, 32'h10, 32'h1000, 32'h1010};
    logic [31:0] rd; logic er; int lat;
    for (int i = 0; i < 6; i++) begin
      xact(we[i], f3[i], ad[i], 32'h12345678, rd, er, lat);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0) begin
        failures++;
        $display("FAIL error_case[%0d] got err=%b rdata=%h want 1/0", i, er, rd);
      end
    end
    xact(1'b0, WORD, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD5AEF) begin failures++; $display("FAIL error_no_write got %h want dead5aef", rd); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    b1.req_valid = 1; b1.req_we = 0; b1.req_funct3 = WORD; b1.req_addr = 32'h10;
    b1.rsp_ready = 0;
    @(negedge clk);
    b1.req_valid = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (b1.rsp_valid !== 1'b1 || b1.rsp_rdata !== 32'hDEAD5AEF || b1.req_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall[%0d] got valid=%b rdata=%h ready=%b want 1/dead5aef/0",
                 i, b1.rsp_valid, b1.rsp_rdata, b1.req_ready);
      end
      @(negedge clk);
    end
    b1.rsp_ready = 1;
    @(negedge clk);
    checks++;
    if (b1.rsp_valid !== 1'b0 || b1.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release got valid=%b ready=%b want 0/1", b1.rsp_valid, b1.req_ready);
    end
  endtask

  task automatic test_rst_accept();
    logic [31:0] rd; logic er; int lat;
    @(negedge clk);
    rst = 1;
    b1.req_valid = 1; b1.req_we = 1; b1.req_funct3 = WORD; b1.req_addr = 32'h10;
    b1.req_wdata = 32'h12345678;
    @(negedge clk);
    b1.req_valid = 0;
    rst = 0;
    @(negedge clk);
    checks++;
    if (b1.rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_accept_rsp got %b want 0", b1.rsp_valid); end
    xact(1'b0, WORD, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD5AEF) begin failures++; $display("FAIL rst_accept_no_write got %h want dead5aef", rd); end
  endtask

  task automatic test_wait_reset();
    int lat;
    @(negedge clk);
    b2.req_valid = 1; b2.req_we = 1; b2.req_funct3 = WORD; b2.req_addr = 32'h20;
    b2.req_wdata = 32'hCAFEF00D; b2.rsp_ready = 1;
    @(negedge clk);
    b2.req_valid = 0;
    checks++;
    if (b2.rsp_valid !== 1'b0) begin failures++; $display("FAIL wait_early_valid got %b want 0", b2.rsp_valid); end
    rst2 = 1;
    @(negedge clk);
    rst2 = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (b2.rsp_valid !== 1'b0) begin failures++; $display("FAIL wait_reset_valid[%0d] got %b want 0", i, b2.rsp_valid); end
      @(negedge clk);
    end
    checks++;
    if (b2.req_ready !== 1'b1) begin failures++; $display("FAIL wait_reset_ready got %b want 1", b2.req_ready); end
    b2.req_valid = 1; b2.req_we = 0; b2.req_funct3 = WORD; b2.req_addr = 32'h20;
    @(negedge clk);
    b2.req_valid = 0;
    lat = 1;
    while (!b2.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL lat3_latency got %0d want 3", lat); end
    checks++;
    if (b2.rsp_rdata !== 32'hCAFEF00D || b2.rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL lat3_committed got %h/%b want cafef00d/0", b2.rsp_rdata, b2.rsp_err);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword_load();
    test_byte_store();
    test_misalign();
    test_errors();
    test_stall();
    test_rst_accept();
    test_wait_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder: the memory-side end of the core's load/store request interface. It accepts one load or store per handshake, decodes the `LOAD_STORE_FNS::funct3_t` size code into byte lanes, and commits stores into an internal word array. It returns sign- or zero-extended load data, or an error, after a fixed latency. It sits behind the core's LSU in place of an external data bus.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words in the array; power of two, ≥ 4.
- `LATENCY`, 1: cycles from request acceptance to `rsp_valid`; legal range 1..4.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: `LOAD_STORE_FNS::funct3_t` size/sign code.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: request was illegal and had no effect.

## Operation
- States: IDLE, WAIT, RESP.
- `req_ready` = (state == IDLE) && !rst.
- Accept means `req_valid && req_ready` at a rising edge.
- On accept:
  - Decode and check the request.
  - Store: write the enabled byte lanes of word `req_addr[2 +: log2(DEPTH_WORDS)]`.
  - Load: capture the selected bytes, extend them, and latch them into the response register.
  - Load the latency counter with LATENCY−1.
  - Go to RESP if LATENCY == 1; otherwise go to WAIT.
- WAIT: decrement the counter each cycle; enter RESP when it reaches 0.
- RESP:
  - `rsp_valid` = 1.
  - `rsp_rdata` and `rsp_err` are held stable until `rsp_valid && rsp_ready`, then the block returns to IDLE.
- Requests never overlap; `req_valid` is ignored outside IDLE.
- Byte lanes:
  - BYTE/BYTE_U select lane `addr[1:0]`.
  - HALF/HALF_U select lanes {`addr[1]`*2, +1}.
  - WORD selects all four lanes.
- Extension: BYTE and HALF sign-extend; BYTE_U and HALF_U zero-extend.
- Store data is replicated across the lanes (byte ×4, half ×2) before lane enables are applied.
- Error conditions set `rsp_err` = 1, force `rsp_rdata` = 0, and suppress the write:
  - funct3 ∈ {011, 110, 111};
  - a store with BYTE_U or HALF_U;
  - `req_addr` ≥ 4·DEPTH_WORDS;
  - misalignment (see Configuration).
- Array contents are not reset and power up unknown.

## Timing
- Reset values: `req_ready` 0 while `rst` is high, then 1 in the first cycle after release; `rsp_valid` 0; `rsp_rdata` 0; `rsp_err` 0; state IDLE; counter 0.
- Acceptance at edge N gives `rsp_valid` = 1 in the cycle after edge N+LATENCY−1.
- With LATENCY = 1, the response is visible in the cycle immediately after acceptance.
- A store's effect is visible to any load accepted at edge N+1 or later.
- Response handshake at edge M gives `req_ready` = 1 in the cycle after M. Best throughput is therefore one request per LATENCY+1 cycles.
- `rst` asserted in WAIT or RESP: the pending response is discarded and the state returns to IDLE. A store accepted before the reset remains committed.
- Simultaneous `rst` and accept: reset wins; there is no write and no response.

## Configuration
- Macro: `DMEM_MISALIGN_TRAP_EN`.
- Defined:
  - HALF/HALF_U with `addr[0]` = 1 is an error.
  - WORD with `addr[1:0]` ≠ 0 is an error.
- Undefined:
  - Misaligned addresses are silently aligned down: HALF clears `addr[0]`, WORD clears `addr[1:0]`.
  - No misalignment error is raised.
  - All other error conditions remain.

## Structure
- Shared package:
  - `LOAD_STORE_FNS::funct3_t` is reused unchanged.
  - Add `dmem_state_t` (IDLE/WAIT/RESP) to `LOAD_STORE_FNS`.
  - Add a localparam `DMEM_MAX_LATENCY` = 4 to `LOAD_STORE_FNS`.
- Sub-module `lsu_lane_align` is combinational. It maps funct3, `addr[1:0]`, and wdata/rdata word to byte enables, the replicated store word, extended load data, and the illegal/misaligned flags.
- `dmem_responder` holds the FSM, the counter, the array, and the response registers.

## Test plan
- Reset, then WORD store of 0xDEADBEEF at 0x10, then WORD load of 0x10 → `rsp_rdata` 0xDEADBEEF, `rsp_err` 0; `rsp_valid` exactly LATENCY cycles after each accept.
- Given the 0xDEADBEEF store above: BYTE load at 0x13 → 0xFFFFFFDE; BYTE_U at 0x13 → 0x000000DE; HALF at 0x10 → 0xFFFFBEEF; HALF_U at 0x12 → 0x0000DEAD.
- BYTE store of 0x5A at 0x11 over 0xDEADBEEF, then WORD load of 0x10 → 0xDEAD5AEF.
- HALF load at 0x11, with the macro defined → `rsp_err` 1, `rsp_rdata` 0, array unchanged; without the macro → data of the half at 0x10.
- Store with funct3 100; load with funct3 011; WORD load at address 4·DEPTH_WORDS → `rsp_err` 1 in each case, no array change.
- `rsp_ready` held low 5 cycles in RESP → `rsp_valid`/`rsp_rdata` stable and `req_ready` 0 throughout. Separately, `rst` pulsed in WAIT → `rsp_valid` stays 0 and `req_ready` = 1 one cycle after release.
